// File: rtl/stream_packet_arbiter.sv
// -----------------------------------------------------------------------------
// stream_packet_arbiter
//
// Two-requester AXI-Stream packet arbiter feeding a single downstream DMA
// bridge port. Whole packets are granted round-robin; the owner keeps the
// output until its TLAST beat is accepted. Each requester supplies a LEN
// word count that is latched at grant time and checked against the number
// of beats actually delivered.
//
// Build option:
//   ARB_LEN_HEADER_EN  - when defined, one header word carrying the latched
//                        LEN is emitted before each payload (HDR state).
//                        When undefined, the arbiter goes straight to XFER.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN       clock, asynchronous active-low reset
//   S0_AXIS_*, S0_LEN             requester 0 stream in + payload length
//   S1_AXIS_*, S1_LEN             requester 1 stream in + payload length
//   M_AXIS_*                      merged stream out
//   GRANT                         one-hot current owner, 00 when idle
//   PKT_CNT0, PKT_CNT1            completed-packet counts (wrapping)
//   LEN_ERR                       sticky beat-count/LEN mismatch flag
//   ERR_CLR                       synchronous clear of LEN_ERR
// -----------------------------------------------------------------------------
module stream_packet_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESETN,

  input  logic [DATA_W-1:0]   S0_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S0_AXIS_TKEEP,
  input  logic                S0_AXIS_TLAST,
  input  logic                S0_AXIS_TVALID,
  output logic                S0_AXIS_TREADY,
  input  logic [15:0]         S0_LEN,

  input  logic [DATA_W-1:0]   S1_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S1_AXIS_TKEEP,
  input  logic                S1_AXIS_TLAST,
  input  logic                S1_AXIS_TVALID,
  output logic                S1_AXIS_TREADY,
  input  logic [15:0]         S1_LEN,

  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,

  output logic [1:0]          GRANT,
  output logic [15:0]         PKT_CNT0,
  output logic [15:0]         PKT_CNT1,
  output logic                LEN_ERR,
  input  logic                ERR_CLR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [1:0]  grant_q;
  logic [15:0] len_q;
  logic [15:0] beat_cnt;
  logic        last_grant;   // index of the requester that finished last

  // Combinational decode results consumed by the register process.
  logic        start;        // grant issued this cycle
  logic        pick;         // requester index chosen at grant
  logic        beat_acc;     // payload beat accepted this cycle
  logic        pkt_end;      // TLAST beat accepted this cycle

  // Current owner's source stream.
  logic              owner;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W/8-1:0] src_keep;
  logic              src_last;
  logic              src_valid;
  logic [15:0]       beat_next;

  assign owner     = grant_q[1];
  assign src_data  = owner ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
  assign src_keep  = owner ? S1_AXIS_TKEEP  : S0_AXIS_TKEEP;
  assign src_last  = owner ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
  assign src_valid = owner ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign beat_next = beat_cnt + 16'd1;

  assign GRANT = grant_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state     = state;
    start          = 1'b0;
    pick           = 1'b0;
    beat_acc       = 1'b0;
    pkt_end        = 1'b0;
    M_AXIS_TDATA   = '0;
    M_AXIS_TKEEP   = '0;
    M_AXIS_TLAST   = 1'b0;
    M_AXIS_TVALID  = 1'b0;
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;

    case (state)
      IDLE: begin
        if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
          start = 1'b1;
          // Contention goes to whoever did not finish last.
          pick  = (S0_AXIS_TVALID && S1_AXIS_TVALID) ? ~last_grant : S1_AXIS_TVALID;
`ifdef ARB_LEN_HEADER_EN
          next_state = HDR;
`else
          next_state = XFER;
`endif
        end
      end

      HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = len_q;
        M_AXIS_TKEEP  = '1;
        if (M_AXIS_TREADY) next_state = XFER;
      end

      XFER: begin
        M_AXIS_TDATA  = src_data;
        M_AXIS_TKEEP  = src_keep;
        M_AXIS_TLAST  = src_last;
        M_AXIS_TVALID = src_valid;
        if (owner) S1_AXIS_TREADY = M_AXIS_TREADY;
        else       S0_AXIS_TREADY = M_AXIS_TREADY;
        beat_acc = src_valid && M_AXIS_TREADY;
        if (beat_acc && src_last) begin
          pkt_end    = 1'b1;
          next_state = IDLE;   // grant is re-evaluated only from IDLE
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state      <= IDLE;
      grant_q    <= 2'b00;
      len_q      <= '0;
      beat_cnt   <= '0;
      PKT_CNT0   <= '0;
      PKT_CNT1   <= '0;
      LEN_ERR    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;

      if (start) begin
        grant_q  <= pick ? 2'b10 : 2'b01;
        len_q    <= pick ? S1_LEN : S0_LEN;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_next;
      end

      if (pkt_end) begin
        grant_q    <= 2'b00;
        last_grant <= owner;
        if (owner) PKT_CNT1 <= PKT_CNT1 + 16'd1;
        else       PKT_CNT0 <= PKT_CNT0 + 16'd1;
      end

      // A mismatch at packet end takes priority over a clear request.
      if (pkt_end && (beat_next != len_q)) LEN_ERR <= 1'b1;
      else if (ERR_CLR)                    LEN_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_packet_arbiter
//
// Self-checking bench for stream_packet_arbiter. Packets are generated as
// queues of beats; a reference model builds the expected merged stream from
// the arbitration rules (round-robin between whole packets, optional LEN
// header word) and tracks packet counts and the sticky length-error flag.
// A monitor records every accepted output beat and checks idle/ownership
// ready rules each cycle. Works with ARB_LEN_HEADER_EN defined or not.
// -----------------------------------------------------------------------------
module tb_stream_packet_arbiter;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESETN;
  logic [15:0] S0_AXIS_TDATA, S1_AXIS_TDATA, M_AXIS_TDATA;
  logic [1:0]  S0_AXIS_TKEEP, S1_AXIS_TKEEP, M_AXIS_TKEEP;
  logic        S0_AXIS_TLAST, S1_AXIS_TLAST, M_AXIS_TLAST;
  logic        S0_AXIS_TVALID, S1_AXIS_TVALID, M_AXIS_TVALID;
  logic        S0_AXIS_TREADY, S1_AXIS_TREADY, M_AXIS_TREADY;
  logic [15:0] S0_LEN, S1_LEN;
  logic [1:0]  GRANT;
  logic [15:0] PKT_CNT0, PKT_CNT1;
  logic        LEN_ERR, ERR_CLR;

  stream_packet_arbiter dut (
    .AXIS_ACLK     (AXIS_ACLK),
    .AXIS_ARESETN  (AXIS_ARESETN),
    .S0_AXIS_TDATA (S0_AXIS_TDATA),
    .S0_AXIS_TKEEP (S0_AXIS_TKEEP),
    .S0_AXIS_TLAST (S0_AXIS_TLAST),
    .S0_AXIS_TVALID(S0_AXIS_TVALID),
    .S0_AXIS_TREADY(S0_AXIS_TREADY),
    .S0_LEN        (S0_LEN),
    .S1_AXIS_TDATA (S1_AXIS_TDATA),
    .S1_AXIS_TKEEP (S1_AXIS_TKEEP),
    .S1_AXIS_TLAST (S1_AXIS_TLAST),
    .S1_AXIS_TVALID(S1_AXIS_TVALID),
    .S1_AXIS_TREADY(S1_AXIS_TREADY),
    .S1_LEN        (S1_LEN),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .GRANT         (GRANT),
    .PKT_CNT0      (PKT_CNT0),
    .PKT_CNT1      (PKT_CNT1),
    .LEN_ERR       (LEN_ERR),
    .ERR_CLR       (ERR_CLR)
  );

  initial forever #5 AXIS_ACLK = ~AXIS_ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Beat encoding: {data[15:0], keep[1:0], last}
  logic [18:0] q0[$], q1[$], exp_q[$], obs_q[$];
  logic [15:0] len0, len1;

  // Reference model state
  int unsigned exp_cnt0, exp_cnt1;
  bit          exp_err;
  int          last_win;

  bit   rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;
  bit   gaps      = 1'b0;
  bit   d0, d1;

  // Downstream ready: fixed or random, changed just after each rising edge.
  initial forever begin
    @(posedge AXIS_ACLK);
    #1;
    M_AXIS_TREADY = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Output monitor plus per-cycle ownership/idle rules.
  initial forever begin
    logic bad;
    @(negedge AXIS_ACLK);
    if (M_AXIS_TVALID && M_AXIS_TREADY)
      obs_q.push_back({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST});
    case (GRANT)
      2'b00:   bad = M_AXIS_TVALID || M_AXIS_TLAST || (M_AXIS_TDATA != 0) ||
                     (M_AXIS_TKEEP != 0) || S0_AXIS_TREADY || S1_AXIS_TREADY;
      2'b01:   bad = S1_AXIS_TREADY;
      2'b10:   bad = S0_AXIS_TREADY;
      default: bad = 1'b1;
    endcase
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL ownership_rules t=%0t grant=%b m_valid=%b m_data=%h s0_ready=%b s1_ready=%b required idle outputs zero / only owner ready",
               $time, GRANT, M_AXIS_TVALID, M_AXIS_TDATA, S0_AXIS_TREADY, S1_AXIS_TREADY);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge AXIS_ACLK);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [18:0] b, input logic [15:0] len);
    if (s == 0) begin
      S0_AXIS_TVALID = v; S0_AXIS_TDATA = b[18:3]; S0_AXIS_TKEEP = b[2:1];
      S0_AXIS_TLAST = b[0]; S0_LEN = len;
    end else begin
      S1_AXIS_TVALID = v; S1_AXIS_TDATA = b[18:3]; S1_AXIS_TKEEP = b[2:1];
      S1_AXIS_TLAST = b[0]; S1_LEN = len;
    end
  endtask

  function automatic logic [18:0] get_beat(input int s, input int i);
    return (s == 0) ? q0[i] : q1[i];
  endfunction

  task automatic make_pkt(input int s, input logic [15:0] len, input int n);
    logic [18:0] b;
    if (s == 0) begin q0.delete(); len0 = len; end
    else        begin q1.delete(); len1 = len; end
    for (int i = 0; i < n; i++) begin
      b = {16'($urandom), 2'($urandom_range(1, 3)), 1'(i == n - 1)};
      if (s == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // Model: a granted packet contributes (header) + payload to the merged stream.
  task automatic add_expected(input int s);
    logic [15:0] len;
    int n;
    len = (s == 0) ? len0 : len1;
    n   = (s == 0) ? q0.size() : q1.size();
`ifdef ARB_LEN_HEADER_EN
    exp_q.push_back({len, 2'b11, 1'b0});
`endif
    for (int i = 0; i < n; i++) exp_q.push_back(get_beat(s, i));
    if (s == 0) exp_cnt0 = (exp_cnt0 + 1) % 65536;
    else        exp_cnt1 = (exp_cnt1 + 1) % 65536;
    if (n != int'(len)) exp_err = 1'b1;
    last_win = s;
  endtask

  task automatic model_reset();
    exp_cnt0 = 0; exp_cnt1 = 0; exp_err = 1'b0; last_win = 1;
  endtask

  // Presents one source's packet; the first beat is always valid so the
  // request is visible in IDLE, later beats may have random valid gaps.
  task automatic drive(input int s);
    int i = 0;
    int budget = 0;
    int n;
    logic vld, acc;
    logic [15:0] len;
    n   = (s == 0) ? q0.size() : q1.size();
    len = (s == 0) ? len0 : len1;
    while (i < n) begin
      vld = (i == 0 || !gaps) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      set_src(s, vld, get_beat(s, i), len);
      @(negedge AXIS_ACLK);
      acc = vld && ((s == 0) ? S0_AXIS_TREADY : S1_AXIS_TREADY);
      @(posedge AXIS_ACLK);
      #1;
      if (acc) i++;
      budget++;
      if (budget > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL drive_timeout src=%0d beats_sent=%0d required=%0d", s, i, n);
        break;
      end
    end
    set_src(s, 1'b0, 19'd0, len);
  endtask

  task automatic compare_stream(input string name);
    int n;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_beat_count got=%0d required=%0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_beat[%0d] got data=%h keep=%b last=%b required data=%h keep=%b last=%b",
                 name, i, obs_q[i][18:3], obs_q[i][2:1], obs_q[i][0],
                 exp_q[i][18:3], exp_q[i][2:1], exp_q[i][0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string name);
    n_checks++;
    if (PKT_CNT0 !== 16'(exp_cnt0) || PKT_CNT1 !== 16'(exp_cnt1) || LEN_ERR !== exp_err) begin
      n_fail++;
      $display("FAIL %s_status got cnt0=%0d cnt1=%0d err=%b required cnt0=%0d cnt1=%0d err=%b",
               name, PKT_CNT0, PKT_CNT1, LEN_ERR, exp_cnt0, exp_cnt1, exp_err);
    end
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    step(1);
    ERR_CLR = 1'b0;
    exp_err = 1'b0;
  endtask

  // Both sources request together; the model decides who goes first.
  task automatic run_pair();
    int first;
    first = (last_win == 0) ? 1 : 0;
    add_expected(first);
    add_expected(1 - first);
    fork
      drive(0);
      drive(1);
    join
    step(3);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    AXIS_ARESETN = 1'b0;
    ERR_CLR = 1'b0;
    set_src(0, 1'b1, 19'h7ffff, 16'd5);
    set_src(1, 1'b1, 19'h7ffff, 16'd5);
    model_reset();
    step(3);
    n_checks++;
    if (GRANT !== 2'b00 || M_AXIS_TVALID !== 1'b0 || S0_AXIS_TREADY !== 1'b0 ||
        S1_AXIS_TREADY !== 1'b0 || PKT_CNT0 !== 0 || PKT_CNT1 !== 0 || LEN_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got grant=%b m_valid=%b rdy=%b%b cnt0=%0d cnt1=%0d err=%b required all zero",
               GRANT, M_AXIS_TVALID, S0_AXIS_TREADY, S1_AXIS_TREADY, PKT_CNT0, PKT_CNT1, LEN_ERR);
    end
    set_src(0, 1'b0, 19'd0, 16'd0);
    set_src(1, 1'b0, 19'd0, 16'd0);
    step(1);
    AXIS_ARESETN = 1'b1;
    step(2);
    check_status("after_reset");
    obs_q.delete();
  endtask

  task automatic test_round_robin();
    logic [1:0] gq[$], rv[$];
    int rl[$];
    int first, cyc;
    logic [1:0] g_first, g_second;
    gaps = 0; rdy_rand = 0; rdy_fixed = 1'b1;
    make_pkt(0, 16'd1, 1);
    make_pkt(1, 16'd1, 1);
    first    = (last_win == 0) ? 1 : 0;
    g_first  = (first == 0) ? 2'b01 : 2'b10;
    g_second = (first == 0) ? 2'b10 : 2'b01;
    add_expected(first);
    add_expected(1 - first);
    d0 = 0; d1 = 0;
    fork
      begin drive(0); d0 = 1; end
      begin drive(1); d1 = 1; end
    join_none
    cyc = 0;
    while (!(d0 && d1) && cyc < 5000) begin
      @(negedge AXIS_ACLK);
      gq.push_back(GRANT);
      cyc++;
    end
    foreach (gq[i]) begin
      if (rv.size() == 0 || rv[rv.size() - 1] != gq[i]) begin
        rv.push_back(gq[i]); rl.push_back(1);
      end else begin
        rl[rl.size() - 1]++;
      end
    end
    n_checks++;
    if (rv.size() < 4 || rv[0] !== 2'b00 || rv[1] !== g_first || rv[2] !== 2'b00 ||
        rl[2] != 1 || rv[3] !== g_second) begin
      n_fail++;
      $display("FAIL rr_grant_sequence got %p runs %p required 00,%b,00(1 cycle),%b",
               rv, rl, g_first, g_second);
    end
    step(3);
    compare_stream("rr");
    check_status("rr");
  endtask

  task automatic test_single_packet();
    gaps = 0; rdy_rand = 0; rdy_fixed = 1'b1;
    make_pkt(0, 16'd3, 3);
    add_expected(0);
    drive(0);
    step(3);
    compare_stream("single_s0");
    check_status("single_s0");
    make_pkt(0, 16'd2, 2);
    add_expected(0);
    drive(0);
    step(3);
    compare_stream("single_s0_len2");
    check_status("single_s0_len2");
  endtask

  task automatic test_len_err();
    gaps = 0; rdy_rand = 0; rdy_fixed = 1'b1;
    // Short packet with the clear held active: the set must win.
    make_pkt(1, 16'd4, 2);
    ERR_CLR = 1'b1;
    add_expected(1);
    drive(1);
    n_checks++;
    if (LEN_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL len_err_set_wins got=%b required=1", LEN_ERR);
    end
    ERR_CLR = 1'b0;
    step(3);
    compare_stream("short_pkt");
    check_status("short_pkt");
    clear_err();
    check_status("err_clear");
    // LEN of zero still produces the header (if enabled) and flags an error.
    make_pkt(0, 16'd0, 2);
    add_expected(0);
    drive(0);
    step(3);
    compare_stream("len_zero");
    check_status("len_zero");
    clear_err();
  endtask

  task automatic test_backpressure();
    gaps = 1; rdy_rand = 1;
    make_pkt(0, 16'd4, 4);
    make_pkt(1, 16'd5, 5);
    run_pair();
    compare_stream("backpressure");
    check_status("backpressure");
    gaps = 0; rdy_rand = 0;
    step(2);
  endtask

  task automatic test_reset_mid_packet();
    int budget = 0;
    logic acc;
    gaps = 0; rdy_rand = 0; rdy_fixed = 1'b1;
    make_pkt(0, 16'd3, 3);
`ifdef ARB_LEN_HEADER_EN
    exp_q.push_back({16'd3, 2'b11, 1'b0});
`endif
    exp_q.push_back(q0[0]);
    acc = 1'b0;
    set_src(0, 1'b1, q0[0], 16'd3);
    while (!acc && budget < 100) begin
      @(negedge AXIS_ACLK);
      acc = S0_AXIS_TREADY;
      @(posedge AXIS_ACLK);
      #1;
      budget++;
    end
    set_src(0, 1'b1, q0[1], 16'd3);
    #1;
    AXIS_ARESETN = 1'b0;
    #1;
    n_checks++;
    if (!acc || M_AXIS_TVALID !== 1'b0 || PKT_CNT0 !== 16'd0 || GRANT !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_packet got first_beat_taken=%b m_valid=%b cnt0=%0d grant=%b required 1,0,0,00",
               acc, M_AXIS_TVALID, PKT_CNT0, GRANT);
    end
    model_reset();
    set_src(0, 1'b0, 19'd0, 16'd0);
    step(2);
    AXIS_ARESETN = 1'b1;
    step(1);
    compare_stream("partial_pkt");
    make_pkt(0, 16'd3, 3);
    add_expected(0);
    drive(0);
    step(3);
    compare_stream("after_reset_pkt");
    check_status("after_reset_pkt");
  endtask

  task automatic test_random();
    int s, len, n;
    for (int it = 0; it < 24; it++) begin
      gaps     = 1'($urandom_range(0, 1));
      rdy_rand = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        len = $urandom_range(0, 6);
        n   = ($urandom_range(0, 3) == 0 || len == 0) ? $urandom_range(1, 6) : len;
        make_pkt(k, 16'(len), n);
      end
      if ($urandom_range(0, 1) == 1) begin
        run_pair();
      end else begin
        s = $urandom_range(0, 1);
        add_expected(s);
        drive(s);
        step(3);
      end
      compare_stream("random");
      check_status("random");
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    gaps = 0; rdy_rand = 0;
  endtask

  initial begin
    M_AXIS_TREADY = 1'b1;
    test_reset();
    test_round_robin();
    test_single_packet();
    test_len_err();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
